mmcm_drp_ctrl: RTL and testbench

DRP initiator that reconfigures a Xilinx MMCME2_ADV at run time through its dynamic reconfiguration port.
- Accepts a stream of (address, mask, data) register commands.
- Holds the MMCM in reset for the whole sequence and does a read-modify-write per command.
- Releases reset, waits for LOCKED, then reports done or error.
- Sits beside the clock generator. DCLK is tied to i_clk at integration.

---
 rtl/mmcm_drp_pkg.sv | 44 ++++
 rtl/mmcm_drp_ctrl_if.sv | 36 +++
 rtl/mmcm_drp_ctrl_sync_bit.sv | 31 +++
 rtl/mmcm_drp_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_mmcm_drp_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmcm_drp_pkg.sv
// Purpose : shared types and constants for the MMCM DRP reconfiguration controller.
// Latency : n/a (declarations only).
// Backpressure : n/a.
// Contents: FSM state enum, error codes, DRP widths, cfg command struct, merge helper.
// Optional feature macro: MMCM_DRP_VERIFY_EN adds the VERIFY/WAIT_VF states.
package mmcm_drp_pkg;

  localparam int DRP_AW = 7;
  localparam int DRP_DW = 16;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_DRDY   = 2'b01;
  localparam logic [1:0] ERR_LOCK   = 2'b10;
  localparam logic [1:0] ERR_VERIFY = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT_RD,
    ST_WRITE,
    ST_WAIT_WR,
`ifdef MMCM_DRP_VERIFY_EN
    ST_VERIFY,
    ST_WAIT_VF,
`endif
    ST_WAIT_CMD,
    ST_WAIT_LOCK
  } state_t;

  typedef struct packed {
    logic [DRP_AW-1:0] addr;
    logic [DRP_DW-1:0] mask;
    logic [DRP_DW-1:0] data;
    logic              last;
  } cfg_cmd_t;

  // mask bit 1 keeps the register's current bit, 0 takes the new data bit
  function automatic logic [DRP_DW-1:0] drp_merge(input logic [DRP_DW-1:0] rd,
                                                  input logic [DRP_DW-1:0] mask,
                                                  input logic [DRP_DW-1:0] data);
    return (rd & mask) | (data & ~mask);
  endfunction

endpackage

// File: rtl/mmcm_drp_ctrl_if.sv
// Purpose : bundles the cfg command stream and the DRP bus of the controller.
// Latency : n/a (wires only).
// Backpressure : cfg stream uses valid/ready; DRP uses den/drdy, one access in flight.
// Modports: slave = controller view (accepts cfg, drives DRP); master = host/MMCM view.
interface mmcm_drp_ctrl_if;
  import mmcm_drp_pkg::*;

  logic              i_cfg_valid;
  logic              o_cfg_ready;
  logic [DRP_AW-1:0] i_cfg_addr;
  logic [DRP_DW-1:0] i_cfg_mask;
  logic [DRP_DW-1:0] i_cfg_data;
  logic              i_cfg_last;

  logic [DRP_AW-1:0] o_drp_daddr;
  logic              o_drp_den;
  logic              o_drp_dwe;
  logic [DRP_DW-1:0] o_drp_di;
  logic [DRP_DW-1:0] i_drp_do;
  logic              i_drp_drdy;

  modport slave (
    input  i_cfg_valid, i_cfg_addr, i_cfg_mask, i_cfg_data, i_cfg_last,
    output o_cfg_ready,
    output o_drp_daddr, o_drp_den, o_drp_dwe, o_drp_di,
    input  i_drp_do, i_drp_drdy
  );

  modport master (
    output i_cfg_valid, i_cfg_addr, i_cfg_mask, i_cfg_data, i_cfg_last,
    input  o_cfg_ready,
    input  o_drp_daddr, o_drp_den, o_drp_dwe, o_drp_di,
    output i_drp_do, i_drp_drdy
  );

endinterface

// File: rtl/mmcm_drp_ctrl_sync_bit.sv
// Purpose : multi-flop synchronizer for a single asynchronous level (MMCM LOCKED).
// Latency : SYNC_STAGES cycles of i_clk.
// Backpressure : none.
// Ports: i_clk, i_reset_n (async active-low, clears chain), i_d async input, o_q synced.
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_d};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/mmcm_drp_ctrl.sv
// Purpose : DRP initiator; holds MMCM in reset, read-modify-writes each cfg command, then waits for LOCKED.
// Latency : >= 4 cycles per command (den, drdy wait, den, drdy wait); done/error one cycle after decision.
// Backpressure : o_cfg_ready only in IDLE/WAIT_CMD; DRP strictly one access in flight.
// Ports: i_clk, i_reset_n, bus (cfg stream + DRP, slave modport), o_mmcm_rst, i_mmcm_locked,
//        o_busy, o_done (pulse), o_error (sticky), o_error_code.
// Optional feature macro: MMCM_DRP_VERIFY_EN adds a read-back check after each write.
module mmcm_drp_ctrl
  import mmcm_drp_pkg::*;
#(
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  mmcm_drp_ctrl_if.slave       bus,
  output logic                 o_mmcm_rst,
  input  logic                 i_mmcm_locked,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  output logic [1:0]           o_error_code
);

  localparam int CNT_MAX = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t            state_q, state_d;
  cfg_cmd_t          cmd_q, cmd_d, cfg_in;
  logic [DRP_DW-1:0] di_q, di_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dwe_q, dwe_d;
  logic              ready_q, ready_d;
  logic              rst_q, rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;
  logic              seen_low_q, seen_low_d;
  logic              locked_s, accept, drdy_to, lock_to, fail;
  logic [1:0]        fail_code;

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_d       (i_mmcm_locked),
    .o_q       (locked_s)
  );

  assign cfg_in  = {bus.i_cfg_addr, bus.i_cfg_mask, bus.i_cfg_data, bus.i_cfg_last};
  assign accept  = bus.i_cfg_valid & ready_q;
  // counter holds cycles elapsed since den, so the error flop lands exactly DRDY_TIMEOUT after den
  assign drdy_to = (cnt_q == CNT_W'(DRDY_TIMEOUT - 1));
  assign lock_to = (cnt_q == CNT_W'(LOCK_TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    di_d       = di_q;
    cnt_d      = cnt_q + CNT_W'(1);
    dwe_d      = dwe_q;
    rst_d      = rst_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    code_d     = code_q;
    // a stale high LOCKED from before reset must not count as lock
    seen_low_d = seen_low_q | ~locked_s;
    fail       = 1'b0;
    fail_code  = ERR_NONE;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          cmd_d      = cfg_in;
          err_d      = 1'b0;
          code_d     = ERR_NONE;
          rst_d      = 1'b1;
          busy_d     = 1'b1;
          dwe_d      = 1'b0;
          seen_low_d = 1'b0;
          state_d    = ST_READ;
        end
      end
      ST_READ: begin
        cnt_d   = CNT_W'(1);
        state_d = ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        if (bus.i_drp_drdy) begin
          di_d    = drp_merge(bus.i_drp_do, cmd_q.mask, cmd_q.data);
          dwe_d   = 1'b1;
          state_d = ST_WRITE;
        end else if (drdy_to) begin
          fail      = 1'b1;
          fail_code = ERR_DRDY;
        end
      end
      ST_WRITE: begin
        cnt_d   = CNT_W'(1);
        state_d = ST_WAIT_WR;
      end
      ST_WAIT_WR: begin
        if (bus.i_drp_drdy) begin
          dwe_d = 1'b0;
`ifdef MMCM_DRP_VERIFY_EN
          state_d = ST_VERIFY;
`else
          if (cmd_q.last) begin
            rst_d   = 1'b0;
            cnt_d   = '0;
            state_d = ST_WAIT_LOCK;
          end else begin
            state_d = ST_WAIT_CMD;
          end
`endif
        end else if (drdy_to) begin
          fail      = 1'b1;
          fail_code = ERR_DRDY;
        end
      end
`ifdef MMCM_DRP_VERIFY_EN
      ST_VERIFY: begin
        cnt_d   = CNT_W'(1);
        state_d = ST_WAIT_VF;
      end
      ST_WAIT_VF: begin
        if (bus.i_drp_drdy) begin
          if (bus.i_drp_do != di_q) begin
            fail      = 1'b1;
            fail_code = ERR_VERIFY;
          end else if (cmd_q.last) begin
            rst_d   = 1'b0;
            cnt_d   = '0;
            state_d = ST_WAIT_LOCK;
          end else begin
            state_d = ST_WAIT_CMD;
          end
        end else if (drdy_to) begin
          fail      = 1'b1;
          fail_code = ERR_DRDY;
        end
      end
`endif
      ST_WAIT_CMD: begin
        cnt_d = '0;
        if (accept) begin
          cmd_d   = cfg_in;
          state_d = ST_READ;
        end
      end
      ST_WAIT_LOCK: begin
        if (seen_low_q && locked_s) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (lock_to) begin
          fail      = 1'b1;
          fail_code = ERR_LOCK;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fail) begin
      state_d = ST_IDLE;
      rst_d   = 1'b0;
      busy_d  = 1'b0;
      dwe_d   = 1'b0;
      err_d   = 1'b1;
      code_d  = fail_code;
    end

    // registered so ready is 0 while in reset and rises on the first edge after release
    ready_d = (state_d == ST_IDLE) || (state_d == ST_WAIT_CMD);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      di_q       <= '0;
      cnt_q      <= '0;
      dwe_q      <= 1'b0;
      ready_q    <= 1'b0;
      rst_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= ERR_NONE;
      seen_low_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      di_q       <= di_d;
      cnt_q      <= cnt_d;
      dwe_q      <= dwe_d;
      ready_q    <= ready_d;
      rst_q      <= rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      code_q     <= code_d;
      seen_low_q <= seen_low_d;
    end
  end

`ifdef MMCM_DRP_VERIFY_EN
  assign bus.o_drp_den = (state_q == ST_READ) || (state_q == ST_WRITE) || (state_q == ST_VERIFY);
`else
  assign bus.o_drp_den = (state_q == ST_READ) || (state_q == ST_WRITE);
`endif
  assign bus.o_drp_dwe   = dwe_q;
  assign bus.o_drp_daddr = cmd_q.addr;
  assign bus.o_drp_di    = di_q;
  assign bus.o_cfg_ready = ready_q;
  assign o_mmcm_rst      = rst_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_error         = err_q;
  assign o_error_code    = code_q;

endmodule

// File: tb/tb_mmcm_drp_ctrl.sv
// Purpose : scoreboard bench for mmcm_drp_ctrl with a DRP register model and a LOCKED model.
// Latency : n/a.
// Backpressure : host waits on o_cfg_ready; model answers den with drdy after a fixed latency.
module tb_mmcm_drp_ctrl;

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] di;
  } wr_t;

`ifdef MMCM_DRP_VERIFY_EN
  localparam int ACC_PER_CMD = 3;
`else
  localparam int ACC_PER_CMD = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic locked;
  logic o_mmcm_rst, o_busy, o_done, o_error;
  logic [1:0] o_error_code;

  mmcm_drp_ctrl_if bus ();

  mmcm_drp_ctrl dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .bus           (bus),
    .o_mmcm_rst    (o_mmcm_rst),
    .i_mmcm_locked (locked),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_error       (o_error),
    .o_error_code  (o_error_code)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  wr_t exp_wr_q[$];
  int  exp_ev_q[$];   // 0 = done, 1/2/3 = error code

  // model controls
  bit dead = 1'b0;
  bit corrupt = 1'b0;
  bit lock_stuck = 1'b0;
  int lat = 2;
  int cd = 0;
  logic [15:0] cd_do;
  int relc = 1000;
  bit mem_init = 1'b0;
  logic [15:0] mem [0:127];

  // monitor state
  int den_cnt = 0;
  int dwe_cnt = 0;
  int last_den_cyc = 0;
  logic den_prev = 1'b0;
  logic err_prev = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // DRP register file + LOCKED model
  always @(negedge clk) begin : model
    if (!mem_init) begin
      for (int i = 0; i < 128; i++) mem[i] = 16'hABCD;
      mem_init = 1'b1;
    end
    bus.i_drp_drdy = 1'b0;
    if (!rst_n) cd = 0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        bus.i_drp_drdy = 1'b1;
        bus.i_drp_do   = cd_do;
      end
    end
    if (rst_n && bus.o_drp_den) begin
      if (bus.o_drp_dwe) mem[bus.o_drp_daddr] = bus.o_drp_di;
      if (!dead) begin
        cd    = lat;
        cd_do = (bus.o_drp_dwe || corrupt) ? 16'h0000 : mem[bus.o_drp_daddr];
      end
    end
    if (lock_stuck) begin
      locked = 1'b1;
    end else begin
      if (o_mmcm_rst) relc = 0;
      else if (relc < 1000) relc++;
      locked = (relc >= 100);
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin : monitor
    wr_t e;
    int ev;
    if (rst_n) begin
      if (bus.o_drp_den) begin
        den_cnt++;
        last_den_cyc = cyc;
        check("rst_at_den", 32'(o_mmcm_rst), 1);
        check("rdy_at_den", 32'(bus.o_cfg_ready), 0);
        check("den_one_cycle", 32'(den_prev), 0);
        if (bus.o_drp_dwe) begin
          dwe_cnt++;
          e = (exp_wr_q.size() > 0) ? exp_wr_q.pop_front() : '1;
          check("wr_addr", 32'(bus.o_drp_daddr), 32'(e.addr));
          check("wr_di", 32'(bus.o_drp_di), 32'(e.di));
        end
      end
      if (o_done) begin
        ev = (exp_ev_q.size() > 0) ? exp_ev_q.pop_front() : 9;
        check("done_event", 0, ev);
      end
      if (o_error && !err_prev) begin
        ev = (exp_ev_q.size() > 0) ? exp_ev_q.pop_front() : 9;
        check("error_code", 32'(o_error_code), ev);
      end
      den_prev = bus.o_drp_den;
      err_prev = o_error;
    end else begin
      den_prev = 1'b0;
      err_prev = 1'b0;
    end
  end

  task automatic wait_ready(input string nm);
    int t = 0;
    while (!bus.o_cfg_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    check(nm, 32'(bus.o_cfg_ready), 1);
  endtask

  task automatic send(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d, input logic l);
    @(negedge clk);
    bus.i_cfg_valid = 1'b1;
    bus.i_cfg_addr  = a;
    bus.i_cfg_mask  = m;
    bus.i_cfg_data  = d;
    bus.i_cfg_last  = l;
    wait_ready("send_ready");
    @(posedge clk);
    #1;
    bus.i_cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int t = 0;
    while (o_busy && t < lim) begin
      @(negedge clk);
      t++;
    end
    check(nm, 32'(o_busy), 0);
  endtask

  function automatic logic [31:0] outs();
    return {bus.o_cfg_ready, bus.o_drp_den, bus.o_drp_dwe, bus.o_drp_daddr, bus.o_drp_di,
            o_mmcm_rst, o_busy, o_done, o_error, o_error_code};
  endfunction

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time limit reached, pending wr=%0d ev=%0d", exp_wr_q.size(), exp_ev_q.size());
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d0, w0, t, t0;
    bus.i_cfg_valid = 1'b0;
    bus.i_cfg_addr  = '0;
    bus.i_cfg_mask  = '0;
    bus.i_cfg_data  = '0;
    bus.i_cfg_last  = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_reset", 32'(bus.o_cfg_ready), 1);
    check("busy_after_reset", 32'(o_busy), 0);

    // T1: single command, rd 0xABCD -> (0xABCD&0x1000)|(0x0041&~0x1000) = 0x0041
    exp_wr_q.push_back('{addr: 7'h08, di: 16'h0041});
    exp_ev_q.push_back(0);
    send(7'h08, 16'h1000, 16'h0041, 1'b1);
    check("t1_rst_on_accept", 32'(o_mmcm_rst), 1);
    check("t1_busy_on_accept", 32'(o_busy), 1);
    check("t1_ready_in_read", 32'(bus.o_cfg_ready), 0);
    wait_idle("t1_complete", 1000);
    check("t1_no_error", 32'(o_error), 0);
    repeat (3) @(negedge clk);

    // T2: three commands with 20-cycle host stalls
    //   0x09: (0xABCD&0xFF00)|(0x1234&0x00FF) = 0xAB34
    //   0x0A: mask 0 -> 0x5A5A ; 0x0B: mask FFFF -> 0xABCD
    exp_wr_q.push_back('{addr: 7'h09, di: 16'hAB34});
    exp_wr_q.push_back('{addr: 7'h0A, di: 16'h5A5A});
    exp_wr_q.push_back('{addr: 7'h0B, di: 16'hABCD});
    exp_ev_q.push_back(0);
    d0 = den_cnt;
    w0 = dwe_cnt;
    send(7'h09, 16'hFF00, 16'h1234, 1'b0);
    wait_ready("t2_wait_cmd1");
    repeat (20) @(negedge clk);
    check("t2_rst_held1", 32'(o_mmcm_rst), 1);
    check("t2_busy_held1", 32'(o_busy), 1);
    send(7'h0A, 16'h0000, 16'h5A5A, 1'b0);
    wait_ready("t2_wait_cmd2");
    repeat (10) @(negedge clk);
    check("t2_rst_mid_stall", 32'(o_mmcm_rst), 1);
    repeat (10) @(negedge clk);
    check("t2_rst_held2", 32'(o_mmcm_rst), 1);
    send(7'h0B, 16'hFFFF, 16'h0000, 1'b1);
    wait_idle("t2_complete", 1000);
    check("t2_den_pulses", den_cnt - d0, 3 * ACC_PER_CMD);
    check("t2_dwe_pulses", dwe_cnt - w0, 3);
    repeat (3) @(negedge clk);

    // T3: drdy never arrives -> error 01 exactly 64 cycles after den
    dead = 1'b1;
    exp_ev_q.push_back(1);
    send(7'h0C, 16'h00FF, 16'h1100, 1'b1);
    wait_idle("t3_error_exit", 200);
    check("t3_timeout_cycles", cyc - last_den_cyc, 64);
    check("t3_code", 32'(o_error_code), 1);
    check("t3_rst_low", 32'(o_mmcm_rst), 0);
    check("t3_error_set", 32'(o_error), 1);
    dead = 1'b0;
    repeat (3) @(negedge clk);
    // fresh command: (0xABCD&0x00FF)|(0x1100&0xFF00) = 0x11CD
    exp_wr_q.push_back('{addr: 7'h0C, di: 16'h11CD});
    exp_ev_q.push_back(0);
    send(7'h0C, 16'h00FF, 16'h1100, 1'b1);
    check("t3_error_cleared", 32'(o_error), 0);
    check("t3_code_cleared", 32'(o_error_code), 0);
    wait_idle("t3_recover", 1000);
    repeat (3) @(negedge clk);

    // T4: LOCKED stuck high -> error 10 after 65535 cycles in WAIT_LOCK
    lock_stuck = 1'b1;
    repeat (5) @(negedge clk);
    exp_wr_q.push_back('{addr: 7'h0D, di: 16'hABCD});
    exp_ev_q.push_back(2);
    send(7'h0D, 16'hFFFF, 16'h0000, 1'b1);
    t = 0;
    while (o_mmcm_rst && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("t4_rst_released", 32'(o_mmcm_rst), 0);
    t0 = cyc;
    wait_idle("t4_error_exit", 70000);
    check("t4_lock_cycles", cyc - t0, 65535);
    check("t4_code", 32'(o_error_code), 2);
    lock_stuck = 1'b0;
    repeat (3) @(negedge clk);

    // T5: reset asserted in WAIT_WR aborts immediately
    exp_wr_q.push_back('{addr: 7'h0E, di: 16'h7777});
    send(7'h0E, 16'h0000, 16'h7777, 1'b1);
    t = 0;
    while (!(bus.o_drp_den && bus.o_drp_dwe) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("t5_write_seen", 32'(bus.o_drp_dwe), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_async_reset_outputs", outs(), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_ready_after_reset", 32'(bus.o_cfg_ready), 1);
    // (0xABCD&0x00F0)|(0x1234&0xFF0F) = 0x12C4
    exp_wr_q.push_back('{addr: 7'h0F, di: 16'h12C4});
    exp_ev_q.push_back(0);
    send(7'h0F, 16'h00F0, 16'h1234, 1'b1);
    wait_idle("t5_fresh_complete", 1000);
    repeat (3) @(negedge clk);

    // T6: readback corrupted to 0x0000; mask 0 so write is 0x00A5
    corrupt = 1'b1;
    exp_wr_q.push_back('{addr: 7'h10, di: 16'h00A5});
`ifdef MMCM_DRP_VERIFY_EN
    exp_ev_q.push_back(3);
`else
    exp_ev_q.push_back(0);
`endif
    send(7'h10, 16'h0000, 16'h00A5, 1'b1);
    wait_idle("t6_complete", 1000);
    corrupt = 1'b0;
    repeat (3) @(negedge clk);

    check("wr_queue_drained", exp_wr_q.size(), 0);
    check("event_queue_drained", exp_ev_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
